// File: rtl/issue_ctrl.sv
// -----------------------------------------------------------------------------
// issue_ctrl
//
// In-order issue controller sitting between the instruction decoder and the
// RV64I execute datapath. Holds one decoded instruction in an issue register,
// stalls on register hazards against outstanding loads (32-entry scoreboard),
// serialises control transfers until they resolve, and halts permanently on an
// unsupported opcode until reset.
//
// Ports
//   clk_i            clock
//   rst_i            synchronous, active-high reset
//   dec_valid_i      decoder offers an instruction
//   dec_ready_o      controller accepts this cycle (combinational on dec_inst_i)
//   dec_inst_i       raw 32-bit instruction
//   dec_pc_i         instruction PC
//   issue_valid_o    issue register holds an instruction
//   issue_ready_i    execute consumes the issued instruction
//   issue_inst_o     issued instruction
//   issue_pc_o       issued PC
//   wb_valid_i       load writeback completes
//   wb_rd_i          destination register of the completing load
//   resolve_valid_i  control transfer resolved
//   resolve_taken_i  resolved transfer redirects the PC
//   flush_o          one-cycle fetch flush pulse
//   illegal_o        sticky illegal-opcode flag
//   stall_cnt_o      count of cycles the decoder was offering but refused
// -----------------------------------------------------------------------------
module issue_ctrl #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dec_valid_i,
  output logic                  dec_ready_o,
  input  logic [31:0]           dec_inst_i,
  input  logic [DATA_WIDTH-1:0] dec_pc_i,
  output logic                  issue_valid_o,
  input  logic                  issue_ready_i,
  output logic [31:0]           issue_inst_o,
  output logic [DATA_WIDTH-1:0] issue_pc_o,
  input  logic                  wb_valid_i,
  input  logic [4:0]            wb_rd_i,
  input  logic                  resolve_valid_i,
  input  logic                  resolve_taken_i,
  output logic                  flush_o,
  output logic                  illegal_o,
  output logic [31:0]           stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BR_WAIT = 2'd1,
    FLUSH   = 2'd2,
    HALT    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [31:0]           r_sb;
  logic [31:0]           w_sb_nxt;
  logic                  r_issue_valid;
  logic [31:0]           r_issue_inst;
  logic [DATA_WIDTH-1:0] r_issue_pc;
  logic                  r_illegal;
  logic [31:0]           r_stall_cnt;

  // Decode of the offered instruction
  logic [6:0] w_opcode;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [4:0] w_rd;
  logic       w_use_rs1;
  logic       w_use_rs2;
  logic       w_use_rd;
  logic       w_is_load;
  logic       w_is_ctrl;
  logic       w_legal;
  logic       w_hazard;
  logic       w_accept;

  assign w_opcode = dec_inst_i[6:0];
  assign w_rs1    = dec_inst_i[19:15];
  assign w_rs2    = dec_inst_i[24:20];
  assign w_rd     = dec_inst_i[11:7];

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_use_rd  = 1'b0;
    w_is_load = 1'b0;
    w_is_ctrl = 1'b0;
    w_legal   = 1'b1;
    unique case (w_opcode)
      7'h33, 7'h3b: begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_rd = 1'b1; end
      7'h13, 7'h1b: begin w_use_rs1 = 1'b1; w_use_rd = 1'b1; end
      7'h67:        begin w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_is_ctrl = 1'b1; end
      7'h03:        begin w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_is_load = 1'b1; end
      7'h23:        begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      7'h63:        begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_is_ctrl = 1'b1; end
      7'h6f:        begin w_use_rd = 1'b1; w_is_ctrl = 1'b1; end
      7'h17, 7'h37: begin w_use_rd = 1'b1; end
      default:      w_legal = 1'b0;
    endcase
  end

  // x0 can never be marked busy, so no explicit x0 masking is needed here.
  // Only the registered scoreboard is consulted: a writeback this cycle
  // releases the dependent instruction one cycle later, never the same cycle.
  assign w_hazard = (w_use_rs1 && r_sb[w_rs1]) ||
                    (w_use_rs2 && r_sb[w_rs2]) ||
                    (w_use_rd  && r_sb[w_rd]);

  assign dec_ready_o = (r_state == RUN) && (!r_issue_valid || issue_ready_i) && !w_hazard;
  assign w_accept    = dec_valid_i && dec_ready_o;

  // Scoreboard update: clear on writeback first, then set, so a load that
  // targets the register being written back in the same cycle stays busy.
  always_comb begin
    w_sb_nxt = r_sb;
    if (wb_valid_i)
      w_sb_nxt[wb_rd_i] = 1'b0;
    if (w_accept && w_is_load && (w_rd != 5'd0))
      w_sb_nxt[w_rd] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN: begin
        if (w_accept) begin
          if (!w_legal)
            w_state_nxt = HALT;
          else if (w_is_ctrl)
            w_state_nxt = BR_WAIT;
        end
      end
      BR_WAIT: begin
        if (resolve_valid_i)
          w_state_nxt = resolve_taken_i ? FLUSH : RUN;
      end
      FLUSH:   w_state_nxt = RUN;
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = RUN;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= RUN;
      r_sb          <= '0;
      r_issue_valid <= 1'b0;
      r_issue_inst  <= '0;
      r_issue_pc    <= '0;
      r_illegal     <= 1'b0;
      r_stall_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sb    <= w_sb_nxt;

      // An accepted illegal instruction is dropped, so the register simply
      // drains if execute is consuming.
      if (w_accept && w_legal) begin
        r_issue_valid <= 1'b1;
        r_issue_inst  <= dec_inst_i;
        r_issue_pc    <= dec_pc_i;
      end else if (issue_ready_i) begin
        r_issue_valid <= 1'b0;
      end

      if (w_accept && !w_legal)
        r_illegal <= 1'b1;

      if (dec_valid_i && !dec_ready_o)
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign issue_valid_o = r_issue_valid;
  assign issue_inst_o  = r_issue_inst;
  assign issue_pc_o    = r_issue_pc;
  // FLUSH lasts exactly one cycle and is a registered state, so the pulse is
  // glitch-free and lands the cycle after the taken resolve.
  assign flush_o       = (r_state == FLUSH);
  assign illegal_o     = r_illegal;
  assign stall_cnt_o   = r_stall_cnt;

endmodule
